// File: rtl/fp_add_seq_ctrl.sv
// rtl/fp_add_seq_ctrl.sv - sequencing FSM for the floating-point adder datapath
module fp_add_seq_ctrl #(
  parameter int MANT_W    = 23,
  parameter int ALIGN_LIM = 26,
  parameter int NORM_MAX  = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] exp_diff,
  input  logic       a_exp_ge_b,
  input  logic       sum_carry,
  input  logic       sum_msb,
  input  logic       sum_zero,
  input  logic [7:0] exp_val,
  output logic       ld_exp,
  output logic       exp_sel,
  output logic       cen_up_exp,
  output logic       cen_down_exp,
  output logic       ld_mant,
  output logic       swap,
  output logic       shr_small,
  output logic       flush_small,
  output logic       ld_sum,
  output logic       shr_sum,
  output logic       shl_sum,
  output logic       clr_exp,
  output logic       busy,
  output logic       done,
  output logic       ovf,
  output logic       unf
);

  // norm_cnt must reach NORM_MAX and also cover a full mantissa-width left walk
  localparam int NORM_SPAN = (NORM_MAX > MANT_W + 2) ? NORM_MAX : MANT_W + 2;
  localparam int CNT_W     = $clog2(NORM_SPAN + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ALIGN = 3'd2;
  localparam logic [2:0] S_ADD   = 3'd3;
  localparam logic [2:0] S_NORM  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]       state, state_nxt;
  logic [7:0]       shift_cnt;
  logic [CNT_W-1:0] norm_cnt;
  logic             ovf_set, unf_set, norm_inc;

  always_comb begin
    state_nxt    = state;
    ld_exp       = 1'b0;
    exp_sel      = 1'b0;
    cen_up_exp   = 1'b0;
    cen_down_exp = 1'b0;
    ld_mant      = 1'b0;
    swap         = 1'b0;
    shr_small    = 1'b0;
    flush_small  = 1'b0;
    ld_sum       = 1'b0;
    shr_sum      = 1'b0;
    shl_sum      = 1'b0;
    clr_exp      = 1'b0;
    done         = 1'b0;
    ovf_set      = 1'b0;
    unf_set      = 1'b0;
    norm_inc     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        ld_mant = 1'b1;
        ld_exp  = 1'b1;
        exp_sel = ~a_exp_ge_b;
        swap    = ~a_exp_ge_b;
        if (exp_diff >= 8'(ALIGN_LIM)) begin
          flush_small = 1'b1;
          state_nxt   = S_ADD;
        end else if (exp_diff == 8'd0) begin
          state_nxt = S_ADD;
        end else begin
          state_nxt = S_ALIGN;
        end
      end
      S_ALIGN: begin
        shr_small = 1'b1;
        if (shift_cnt == 8'd1) state_nxt = S_ADD;
      end
      S_ADD: begin
        ld_sum    = 1'b1;
        state_nxt = S_NORM;
      end
      S_NORM: begin
        // priority order matters: a zero sum wins over carry, carry over msb
        if (sum_zero) begin
          clr_exp   = 1'b1;
          state_nxt = S_DONE;
        end else if (sum_carry && exp_val >= 8'hFE) begin
          shr_sum    = 1'b1;
          cen_up_exp = (exp_val == 8'hFE);
          ovf_set    = 1'b1;
          state_nxt  = S_DONE;
        end else if (sum_carry) begin
          shr_sum    = 1'b1;
          cen_up_exp = 1'b1;
        end else if (sum_msb) begin
          state_nxt = S_DONE;
        end else if (exp_val <= 8'd1) begin
          unf_set   = 1'b1;
          state_nxt = S_DONE;
        end else if (norm_cnt == CNT_W'(NORM_MAX)) begin
          unf_set   = 1'b1;
          state_nxt = S_DONE;
        end else begin
          shl_sum      = 1'b1;
          cen_down_exp = 1'b1;
          norm_inc     = 1'b1;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      shift_cnt <= 8'd0;
      norm_cnt  <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end
      if (ovf_set) ovf <= 1'b1;
      if (unf_set) unf <= 1'b1;
      if (state == S_LOAD) begin
        shift_cnt <= exp_diff;
        norm_cnt  <= '0;
      end
      if (state == S_ALIGN) shift_cnt <= shift_cnt - 8'd1;
      if (norm_inc) norm_cnt <= norm_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_add_seq_ctrl.sv
// tb/tb_fp_add_seq_ctrl.sv - bench for fp_add_seq_ctrl with a reactive datapath and arithmetic reference
module tb_fp_add_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] exp_diff = 8'd0;
  logic       a_exp_ge_b = 1'b1;
  logic       sum_carry, sum_msb, sum_zero;
  logic [7:0] exp_val;
  logic       ld_exp, exp_sel, cen_up_exp, cen_down_exp, ld_mant, swap;
  logic       shr_small, flush_small, ld_sum, shr_sum, shl_sum, clr_exp;
  logic       busy, done, ovf, unf;

  int total = 0;
  int bad = 0;

  // datapath stand-in: exponent counter and sum register driven by the strobes
  logic [7:0]  dp_exp = 8'd0;
  logic [24:0] dp_sum = 25'd0;
  logic [7:0]  exp_a_r = 8'd0, exp_b_r = 8'd0;
  logic [24:0] sum_init = 25'd0;

  fp_add_seq_ctrl #(.MANT_W(23), .ALIGN_LIM(26), .NORM_MAX(25)) dut (
    .clk(clk), .rst(rst), .start(start), .exp_diff(exp_diff), .a_exp_ge_b(a_exp_ge_b),
    .sum_carry(sum_carry), .sum_msb(sum_msb), .sum_zero(sum_zero), .exp_val(exp_val),
    .ld_exp(ld_exp), .exp_sel(exp_sel), .cen_up_exp(cen_up_exp), .cen_down_exp(cen_down_exp),
    .ld_mant(ld_mant), .swap(swap), .shr_small(shr_small), .flush_small(flush_small),
    .ld_sum(ld_sum), .shr_sum(shr_sum), .shl_sum(shl_sum), .clr_exp(clr_exp),
    .busy(busy), .done(done), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  assign exp_val   = dp_exp;
  assign sum_carry = dp_sum[24];
  assign sum_msb   = dp_sum[23];
  assign sum_zero  = (dp_sum == 25'd0);

  always @(posedge clk) begin
    if (ld_exp)            dp_exp <= exp_sel ? exp_b_r : exp_a_r;
    else if (cen_up_exp)   dp_exp <= dp_exp + 8'd1;
    else if (cen_down_exp) dp_exp <= dp_exp - 8'd1;
    else if (clr_exp)      dp_exp <= 8'd0;
    if (ld_sum)            dp_sum <= sum_init;
    else if (shr_sum)      dp_sum <= dp_sum >> 1;
    else if (shl_sum)      dp_sum <= dp_sum << 1;
  end

  function automatic int lead_zeros(input logic [24:0] v);
    for (int i = 23; i >= 0; i--) if (v[i]) return 23 - i;
    return 24;
  endfunction

  task automatic run_op(input logic [7:0] ea, input logic [7:0] eb, input logic [24:0] s,
                        input bit poke, input string tag);
    int e, diff, align, n, k, room, lz, lat_exp, lat, c;
    int x_flush, x_shr, x_up, x_shl, x_clr;
    int n_shr_small, n_flush, n_shr, n_up, n_down, n_shl, n_clr, n_ld_sum, excl, busy_low;
    logic x_ovf, x_unf, got_sel, got_swap, ovf_ld, unf_ld, ovf_end, unf_end, seen_done;
    logic [7:0] x_exp, exp_end;
    // reference: derive everything from operand exponents and the raw sum
    e = (ea >= eb) ? int'(ea) : int'(eb);
    diff = (ea >= eb) ? int'(ea) - int'(eb) : int'(eb) - int'(ea);
    align = (diff > 0 && diff < 26) ? diff : 0;
    x_flush = (diff >= 26) ? 1 : 0;
    x_shr = 0; x_up = 0; x_shl = 0; x_clr = 0; x_ovf = 0; x_unf = 0; n = 0;
    if (s == 25'd0) begin
      x_clr = 1; x_exp = 8'd0;
    end else if (s[24]) begin
      x_shr = 1;
      if (e >= 254) begin
        x_ovf = 1; x_up = (e == 254) ? 1 : 0; x_exp = 8'hFF;
      end else begin
        x_up = 1; n = 1; x_exp = 8'(e + 1);
      end
    end else begin
      lz = lead_zeros(s);
      room = (e > 1) ? e - 1 : 0;
      k = lz;
      if (room < k) k = room;
      if (25 < k) k = 25;
      x_unf = (k < lz);
      x_shl = k; n = k; x_exp = 8'(e - k);
    end
    lat_exp = 3 + align + n + 1;

    n_shr_small = 0; n_flush = 0; n_shr = 0; n_up = 0; n_down = 0; n_shl = 0;
    n_clr = 0; n_ld_sum = 0; excl = 0; busy_low = 0; lat = 0; seen_done = 0;
    got_sel = 0; got_swap = 0; ovf_ld = 0; unf_ld = 0; ovf_end = 0; unf_end = 0; exp_end = 0;

    @(negedge clk);
    exp_a_r = ea; exp_b_r = eb; sum_init = s;
    exp_diff = 8'(diff); a_exp_ge_b = (ea >= eb); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    c = 0;
    while (!seen_done && c < 400) begin
      @(negedge clk);
      c++;
      if (poke && c == 3) start = 1'b1;
      if (poke && c == 4) start = 1'b0;
      if (c == 1) begin
        got_sel = exp_sel; got_swap = swap; ovf_ld = ovf; unf_ld = unf;
      end
      n_shr_small += int'(shr_small); n_flush += int'(flush_small);
      n_shr += int'(shr_sum); n_up += int'(cen_up_exp); n_down += int'(cen_down_exp);
      n_shl += int'(shl_sum); n_clr += int'(clr_exp); n_ld_sum += int'(ld_sum);
      if (int'(ld_exp) + int'(cen_up_exp) + int'(cen_down_exp) + int'(clr_exp) > 1) excl++;
      if (shr_sum && shl_sum) excl++;
      if (!busy) busy_low++;
      if (done) begin
        seen_done = 1; lat = c; ovf_end = ovf; unf_end = unf; exp_end = dp_exp;
      end
    end
    start = 1'b0;

    total++; if (!seen_done) begin bad++; $display("FAIL %s timeout: no done within %0d cycles", tag, c); end
    total++; if (lat !== lat_exp) begin bad++; $display("FAIL %s latency: got %0d want %0d", tag, lat, lat_exp); end
    total++; if (n_shr_small !== align) begin bad++; $display("FAIL %s shr_small: got %0d want %0d", tag, n_shr_small, align); end
    total++; if (n_flush !== x_flush) begin bad++; $display("FAIL %s flush_small: got %0d want %0d", tag, n_flush, x_flush); end
    total++; if (got_sel !== (ea < eb) || got_swap !== (ea < eb)) begin bad++; $display("FAIL %s exp_sel/swap: got %0b/%0b want %0b", tag, got_sel, got_swap, (ea < eb)); end
    total++; if (n_ld_sum !== 1) begin bad++; $display("FAIL %s ld_sum: got %0d want 1", tag, n_ld_sum); end
    total++; if (n_shr !== x_shr || n_up !== x_up) begin bad++; $display("FAIL %s shr_sum/cen_up: got %0d/%0d want %0d/%0d", tag, n_shr, n_up, x_shr, x_up); end
    total++; if (n_shl !== x_shl || n_down !== x_shl) begin bad++; $display("FAIL %s shl_sum/cen_down: got %0d/%0d want %0d", tag, n_shl, n_down, x_shl); end
    total++; if (n_clr !== x_clr) begin bad++; $display("FAIL %s clr_exp: got %0d want %0d", tag, n_clr, x_clr); end
    total++; if (ovf_end !== x_ovf || unf_end !== x_unf) begin bad++; $display("FAIL %s flags: got ovf=%0b unf=%0b want ovf=%0b unf=%0b", tag, ovf_end, unf_end, x_ovf, x_unf); end
    total++; if (ovf_ld !== 1'b0 || unf_ld !== 1'b0) begin bad++; $display("FAIL %s flag clear on start: got ovf=%0b unf=%0b want 0", tag, ovf_ld, unf_ld); end
    total++; if (exp_end !== x_exp) begin bad++; $display("FAIL %s result exp: got %02h want %02h", tag, exp_end, x_exp); end
    total++; if (excl !== 0 || busy_low !== 0) begin bad++; $display("FAIL %s exclusivity/busy: got %0d/%0d violations want 0", tag, excl, busy_low); end
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL %s after done: got busy=%0b done=%0b want 0", tag, busy, done); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({ld_exp, exp_sel, cen_up_exp, cen_down_exp, ld_mant, swap, shr_small, flush_small,
         ld_sum, shr_sum, shl_sum, clr_exp, busy, done, ovf, unf} !== 16'd0) begin
      bad++; $display("FAIL reset outputs: got nonzero strobe/flag pattern want all 0");
    end
    rst = 1'b0;
  endtask

  task automatic test_aligned();     run_op(8'h30, 8'h30, 25'h0C00000, 0, "aligned"); endtask
  task automatic test_alignment();   run_op(8'h40, 8'h45, 25'h0800001, 0, "align5"); endtask
  task automatic test_flush_carry(); run_op(8'h80, 8'h62, 25'h1400000, 0, "flush_carry"); endtask
  task automatic test_norm_left();   run_op(8'h0A, 8'h09, 25'h0100abc, 0, "norm_left3"); endtask
  task automatic test_underflow();   run_op(8'h01, 8'h01, 25'h0001000, 0, "unf_exp1"); endtask
  task automatic test_zero();        run_op(8'h50, 8'h4F, 25'h0000000, 0, "zero_sum"); endtask

  task automatic test_overflow_sticky();
    run_op(8'hFE, 8'hFE, 25'h1800000, 0, "ovf_fe");
    repeat (3) @(negedge clk);
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf sticky in idle: got %0b want 1", ovf); end
    run_op(8'hFF, 8'h10, 25'h1000001, 0, "ovf_ff_flush");
    run_op(8'h20, 8'h21, 25'h0900000, 0, "after_ovf");
  endtask

  task automatic test_reset_mid_align();
    int shifts, c;
    logic saw_done;
    @(negedge clk);
    exp_a_r = 8'd40; exp_b_r = 8'd20; sum_init = 25'h0800000;
    exp_diff = 8'd20; a_exp_ge_b = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    shifts = 0; c = 0;
    while (shifts < 4 && c < 50) begin
      @(negedge clk);
      c++;
      shifts += int'(shr_small);
    end
    rst = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0 || shr_small !== 1'b0) begin bad++; $display("FAIL reset mid-align: got busy=%0b done=%0b shr=%0b want 0", busy, done, shr_small); end
    rst = 1'b0;
    saw_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL reset mid-align activity: got %0b want 0", saw_done); end
  endtask

  task automatic test_start_while_busy();
    run_op(8'h60, 8'h57, 25'h0040000, 1, "busy_start");
    run_op(8'h33, 8'h33, 25'h0800000, 1, "busy_start_min");
  endtask

  task automatic test_random();
    logic [7:0] ea, eb;
    logic [24:0] s;
    int cat, p, d;
    for (int i = 0; i < 40; i++) begin
      ea = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        d = int'(ea) + $urandom_range(0, 60) - 30;
        if (d < 0) d = 0;
        if (d > 255) d = 255;
        eb = 8'(d);
      end else begin
        eb = 8'($urandom_range(0, 255));
      end
      cat = $urandom_range(0, 9);
      if (cat == 0) s = 25'd0;
      else if (cat <= 2) s = {1'b1, 24'($urandom)};
      else if (cat <= 4) s = {2'b01, 23'($urandom)};
      else begin
        p = $urandom_range(0, 22);
        s = (25'd1 << p) | (25'($urandom) & ((25'd1 << p) - 25'd1));
      end
      run_op(ea, eb, s, ($urandom_range(0, 4) == 0), "random");
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_alignment();
    test_flush_carry();
    test_overflow_sticky();
    test_norm_left();
    test_underflow();
    test_zero();
    test_reset_mid_align();
    test_start_while_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_add_seq_ctrl.md
Name: fp_add_seq_ctrl

Overview:
- Sequencing FSM for the floating-point adder datapath.
- Drives the exponent up/down counter, which has load, count-up and count-down enables.
- Drives the mantissa alignment shifter, the adder register and the normalisation shifter.
- Per operation: exponent compare/load, right-align of the smaller mantissa, add, normalise with exponent adjust, then completion and status flags.

Parameters:
- MANT_W, 23, mantissa width excluding hidden bit.
- ALIGN_LIM, 26, exponent difference at or above which the smaller operand is flushed instead of shifted. Must be ≤ 255.
- NORM_MAX, 25, maximum left-shift cycles in NORM before forced exit.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin operation; sampled only in IDLE.
- exp_diff  in  8  |exp_a − exp_b| from datapath, valid while start is high.
- a_exp_ge_b  in  1  exp_a ≥ exp_b, valid while start is high.
- sum_carry  in  1  adder result overflowed past hidden bit.
- sum_msb  in  1  hidden-bit position of result is 1.
- sum_zero  in  1  result mantissa is all zero.
- exp_val  in  8  current exponent counter output.
- ld_exp  out  1  load exponent counter.
- exp_sel  out  1  counter load source: 0 = exp_a, 1 = exp_b.
- cen_up_exp  out  1  increment exponent.
- cen_down_exp  out  1  decrement exponent.
- ld_mant  out  1  load operand mantissa registers.
- swap  out  1  route operand A to the shifter (B is larger).
- shr_small  out  1  shift smaller mantissa right 1.
- flush_small  out  1  clear smaller mantissa.
- ld_sum  out  1  capture adder output.
- shr_sum  out  1  shift sum right 1.
- shl_sum  out  1  shift sum left 1.
- clr_exp  out  1  clear exponent counter (zero result).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- ovf  out  1  exponent overflow flag, sticky.
- unf  out  1  underflow/denormal flag, sticky.

Behaviour:
- Reset: state IDLE; all outputs 0; shift_cnt, norm_cnt and flags cleared. Reset in any state aborts the operation with no done pulse.
- Unless stated otherwise below, all strobes are 0.
- Strobe exclusivity:
  - At most one of ld_exp, cen_up_exp, cen_down_exp, clr_exp is high per cycle.
  - At most one of shr_sum, shl_sum is high per cycle.
- IDLE:
  - start=1 → LOAD; ovf and unf clear on this edge.
  - start while busy is ignored.
- LOAD (1 cycle):
  - ld_mant=1, ld_exp=1, exp_sel=swap=~a_exp_ge_b.
  - shift_cnt ← exp_diff.
  - exp_diff ≥ ALIGN_LIM → flush_small=1, next ADD.
  - exp_diff=0 → next ADD.
  - Otherwise → ALIGN.
  - LOAD samples the operand info captured with start; the datapath holds exp_diff and a_exp_ge_b stable until LOAD completes.
- ALIGN:
  - shr_small=1 each cycle; shift_cnt decrements.
  - Leaves for ADD on the cycle shift_cnt=1.
  - Exactly exp_diff shift cycles.
- ADD (1 cycle): ld_sum=1 → NORM.
- NORM: evaluated each cycle, first match wins.
  1. sum_zero → clr_exp=1, → DONE.
  2. sum_carry and exp_val ≥ 8'hFE → shr_sum=1, cen_up_exp=1 only if exp_val=8'hFE; ovf←1; → DONE.
  3. sum_carry → shr_sum=1, cen_up_exp=1, stay in NORM.
  4. sum_msb → DONE.
  5. exp_val ≤ 1 → unf←1, no shift, → DONE.
  6. norm_cnt = NORM_MAX → unf←1, → DONE.
  7. Otherwise shl_sum=1, cen_down_exp=1, norm_cnt+1, stay in NORM.
- norm_cnt clears in LOAD.
- DONE (1 cycle): done=1 → IDLE. ovf/unf hold until the next accepted start.
- Latency, counted from the start edge to the done cycle: 3 + align_cycles + norm_cycles + 1.
  - align_cycles = exp_diff if 0 < exp_diff < ALIGN_LIM, else 0.
  - norm_cycles = shift/adjust cycles in NORM, excluding the terminating cycle.
  - Minimum latency is 4 (LOAD, ADD, NORM, DONE).
- Outputs are Moore/registered-state decoded. The NORM decision uses same-cycle status inputs, which the datapath provides registered.

Test Plan:
- Aligned add, no shifts: start, exp_diff=0, a_exp_ge_b=1, in NORM sum_msb=1 → ld_exp with exp_sel=0 in LOAD; zero shr_small; done in cycle 4; ovf=unf=0.
- Alignment: exp_diff=5, a_exp_ge_b=0 → swap=exp_sel=1 in LOAD; exactly 5 consecutive shr_small cycles; ld_sum next; done at cycle 9.
- Flush and carry: exp_diff=30 → flush_small one cycle, no ALIGN. In NORM sum_carry=1 with exp_val=8'h80 gives one shr_sum+cen_up_exp; then sum_msb=1 → done. Overflow variant: exp_val=8'hFE with carry → ovf=1 sticky through IDLE, cleared by next start.
- Normalise left: sum_msb low for 3 cycles with exp_val=10 → 3 shl_sum+cen_down_exp pulses. Also exp_val=1 with msb low → unf=1, no shift. Also sum_zero → clr_exp, done.
- Reset mid-ALIGN (exp_diff=20, rst in 4th shift cycle) → next cycle IDLE, busy=0, no done. start during busy is ignored with no restart.
